// File: rtl/regfile_dump_pkg.sv
// Shared definitions for the 8x16 register file and its read-port users,
// including the dump walker's state encoding.
package regfile_dump_pkg;

    localparam int REG_DATA_W = 16;
    localparam int REG_ADDR_W = 3;
    localparam int REG_NUM    = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        SEND  = 3'd2,
        DONE  = 3'd3,
        CSUM  = 3'd4
    } dump_state_t;

endpackage

// File: rtl/regfile_dump_csum.sv
// Modular-sum accumulator over streamed data words.
// Clear has priority over add.
module regfile_dump_csum
    import regfile_dump_pkg::*;
#(
    parameter int DATA_W = REG_DATA_W
) (
    input  logic              clk,
    input  logic              rst_bar,
    input  logic              clear,
    input  logic              add,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] value
);

    logic [DATA_W-1:0] acc;

    always_ff @(posedge clk) begin
        if (!rst_bar) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (add) begin
            acc <= acc + din;
        end
    end

    assign value = acc;

endmodule

// File: rtl/regfile_dump.sv
// Register-file dump walker: reads a wrapping index range through one read
// port and streams each value on valid/ready. Optional trailing checksum
// word when REGFILE_DUMP_CHECKSUM_EN is defined.
module regfile_dump
    import regfile_dump_pkg::*;
#(
    parameter int DATA_W = REG_DATA_W,
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_bar,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_reg,
    input  logic [ADDR_W-1:0] last_reg,
    output logic [ADDR_W-1:0] rf_addr,
    input  logic [DATA_W-1:0] rf_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_idx,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    dump_state_t       state;
    dump_state_t       state_next;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] last_q;
    logic [DATA_W-1:0] data_q;
    logic [ADDR_W-1:0] idx_q;
    logic              last_flag_q;
    logic              handshake;
    logic              at_last;
    logic              start_ok;

    assign handshake = out_valid & out_ready;
    assign at_last   = (ptr == last_q);
    assign start_ok  = (state == IDLE) && start;
    assign rf_addr   = ptr;

`ifdef REGFILE_DUMP_CHECKSUM_EN
    logic [DATA_W-1:0] csum_value;

    regfile_dump_csum #(
        .DATA_W (DATA_W)
    ) u_csum (
        .clk     (clk),
        .rst_bar (rst_bar),
        .clear   (start_ok),
        .add     ((state == SEND) && handshake),
        .din     (data_q),
        .value   (csum_value)
    );
`endif

    always_ff @(posedge clk) begin
        if (!rst_bar) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Pointer and captured word; each register is sampled at its own FETCH edge
    always_ff @(posedge clk) begin
        if (!rst_bar) begin
            ptr         <= '0;
            last_q      <= '0;
            data_q      <= '0;
            idx_q       <= '0;
            last_flag_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        ptr    <= first_reg;
                        last_q <= last_reg;
                    end
                end
                FETCH: begin
                    data_q <= rf_data;
                    idx_q  <= ptr;
`ifdef REGFILE_DUMP_CHECKSUM_EN
                    last_flag_q <= 1'b0;
`else
                    last_flag_q <= at_last;
`endif
                end
                SEND: begin
                    if (handshake && !at_last) begin
                        ptr <= ptr + ADDR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (start) state_next = FETCH;
            FETCH: state_next = SEND;
            SEND: begin
                if (handshake) begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
                    state_next = at_last ? CSUM : FETCH;
`else
                    state_next = at_last ? DONE : FETCH;
`endif
                end
            end
            DONE:  state_next = IDLE;
`ifdef REGFILE_DUMP_CHECKSUM_EN
            CSUM:  if (handshake) state_next = DONE;
`endif
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        done      = (state == DONE);
        out_valid = (state == SEND);
        out_data  = data_q;
        out_idx   = idx_q;
        out_last  = last_flag_q;
`ifdef REGFILE_DUMP_CHECKSUM_EN
        if (state == CSUM) begin
            out_valid = 1'b1;
            out_data  = csum_value;
            out_idx   = '0;
            out_last  = 1'b1;
        end
`endif
    end

endmodule
